// File: rtl/sal_cmd_sched.sv
// Channel command scheduler: picks at most one of REF/RD/WR/ACT/PRE from the bank controllers per cycle under tRRD/tCCD/tWTR/tRTW.
// Latency: grants are combinational in the request cycle; the command bus is registered and shows the grant one cycle later.
// Backpressure: none; a request that is not granted is simply not acknowledged and the bank controller holds it.
//
// Ports: clk/rst (async, active-high); t_*_i timing gaps; *_req_i per-bank request vectors with
// ra_i/ca_i/id_i/len_i per-bank fields; *_gnt_o one-hot grants; cmd_*_o registered DRAM command bus.
// Optional build macro SAL_SCHED_PERF_EN adds 32-bit per-class grant counters perf_{act,cas,pre,ref}_o.
module sal_cmd_sched #(
  parameter int NUM_BANKS = 4,
  parameter int RA_W      = 14,
  parameter int CA_W      = 10,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 4,
  parameter int TW        = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [TW-1:0]                  t_rrd_i,
  input  logic [TW-1:0]                  t_ccd_i,
  input  logic [TW-1:0]                  t_wtr_i,
  input  logic [TW-1:0]                  t_rtw_i,
  input  logic [NUM_BANKS-1:0]           act_req_i,
  input  logic [NUM_BANKS-1:0]           rd_req_i,
  input  logic [NUM_BANKS-1:0]           wr_req_i,
  input  logic [NUM_BANKS-1:0]           pre_req_i,
  input  logic [NUM_BANKS-1:0]           ref_req_i,
  input  logic [NUM_BANKS*RA_W-1:0]      ra_i,
  input  logic [NUM_BANKS*CA_W-1:0]      ca_i,
  input  logic [NUM_BANKS*ID_W-1:0]      id_i,
  input  logic [NUM_BANKS*LEN_W-1:0]     len_i,
  output logic [NUM_BANKS-1:0]           act_gnt_o,
  output logic [NUM_BANKS-1:0]           rd_gnt_o,
  output logic [NUM_BANKS-1:0]           wr_gnt_o,
  output logic [NUM_BANKS-1:0]           pre_gnt_o,
  output logic [NUM_BANKS-1:0]           ref_gnt_o,
  output logic                           cmd_valid_o,
  output logic [2:0]                     cmd_o,
  output logic [$clog2(NUM_BANKS)-1:0]   cmd_ba_o,
  output logic [RA_W-1:0]                cmd_addr_o,
  output logic [ID_W-1:0]                cmd_id_o,
  output logic [LEN_W-1:0]               cmd_len_o
`ifdef SAL_SCHED_PERF_EN
  ,
  output logic [31:0]                    perf_act_o,
  output logic [31:0]                    perf_cas_o,
  output logic [31:0]                    perf_pre_o,
  output logic [31:0]                    perf_ref_o
`endif
);

  localparam int BW = $clog2(NUM_BANKS);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_REF,
    CLS_CAS,
    CLS_ACT,
    CLS_PRE
  } cls_e;

  typedef struct packed {
    logic             vld;
    logic [2:0]       cmd;
    logic [BW-1:0]    ba;
    logic [RA_W-1:0]  addr;
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } bus_t;

  logic [TW-1:0]        rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
  logic [BW-1:0]        rr_ptr;
  logic                 act_ok, rd_ok, wr_ok;
  logic [NUM_BANKS-1:0] act_elig, rd_elig, wr_elig, cas_elig;
  logic [NUM_BANKS-1:0] sel_mask, gnt_oh;
  cls_e                 sel_cls;
  logic [BW-1:0]        gnt_bank;
  logic                 gnt_any;
  logic                 act_fire, rd_fire, wr_fire;
  bus_t                 bus_d, bus_q;

  // Counter value at grant time: zero means "next cycle is already legal".
  function automatic logic [TW-1:0] gap_load(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  function automatic logic [TW-1:0] gap_dec(input logic [TW-1:0] c);
    return (c == '0) ? '0 : c - TW'(1);
  endfunction

  // First set bit of mask scanning upward from ptr with wrap-around.
  function automatic logic [BW-1:0] rr_pick(input logic [NUM_BANKS-1:0] mask,
                                            input logic [BW-1:0]        ptr);
    logic [BW-1:0] idx;
    logic [BW-1:0] pick;
    logic          found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      idx = ptr + BW'(i);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign act_ok = (rrd_cnt == '0);
  assign rd_ok  = (ccd_cnt == '0) && (wtr_cnt == '0);
  assign wr_ok  = (ccd_cnt == '0) && (rtw_cnt == '0);

  // A bank raising RD and WR together is treated as RD only.
  assign act_elig = act_req_i & {NUM_BANKS{act_ok}};
  assign rd_elig  = rd_req_i  & {NUM_BANKS{rd_ok}};
  assign wr_elig  = wr_req_i  & ~rd_req_i & {NUM_BANKS{wr_ok}};
  assign cas_elig = rd_elig | wr_elig;

  // Eligibility is folded in before the class decision so a blocked class falls through.
  always_comb begin
    sel_mask = '0;
    sel_cls  = CLS_NONE;
    if (|ref_req_i) begin
      sel_mask = ref_req_i;
      sel_cls  = CLS_REF;
    end else if (|cas_elig) begin
      sel_mask = cas_elig;
      sel_cls  = CLS_CAS;
    end else if (|act_elig) begin
      sel_mask = act_elig;
      sel_cls  = CLS_ACT;
    end else if (|pre_req_i) begin
      sel_mask = pre_req_i;
      sel_cls  = CLS_PRE;
    end
  end

  assign gnt_bank = rr_pick(sel_mask, rr_ptr);
  assign gnt_any  = (sel_cls != CLS_NONE) && !rst;
  assign gnt_oh   = gnt_any ? (NUM_BANKS'(1) << gnt_bank) : '0;

  assign ref_gnt_o = (sel_cls == CLS_REF) ? gnt_oh : '0;
  assign rd_gnt_o  = (sel_cls == CLS_CAS) ? (gnt_oh & rd_elig) : '0;
  assign wr_gnt_o  = (sel_cls == CLS_CAS) ? (gnt_oh & wr_elig) : '0;
  assign act_gnt_o = (sel_cls == CLS_ACT) ? gnt_oh : '0;
  assign pre_gnt_o = (sel_cls == CLS_PRE) ? gnt_oh : '0;

  assign act_fire = |act_gnt_o;
  assign rd_fire  = |rd_gnt_o;
  assign wr_fire  = |wr_gnt_o;

  always_comb begin
    bus_d = '0;
    if (gnt_any) begin
      bus_d.vld = 1'b1;
      bus_d.ba  = gnt_bank;
      if (act_fire) begin
        bus_d.cmd  = CMD_ACT;
        bus_d.addr = ra_i[int'(gnt_bank)*RA_W +: RA_W];
      end else if (rd_fire || wr_fire) begin
        bus_d.cmd  = rd_fire ? CMD_RD : CMD_WR;
        bus_d.addr = RA_W'(ca_i[int'(gnt_bank)*CA_W +: CA_W]);
        bus_d.id   = id_i[int'(gnt_bank)*ID_W +: ID_W];
        bus_d.len  = len_i[int'(gnt_bank)*LEN_W +: LEN_W];
      end else if (|pre_gnt_o) begin
        bus_d.cmd = CMD_PRE;
      end else begin
        bus_d.cmd = CMD_REF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrd_cnt <= '0;
      ccd_cnt <= '0;
      wtr_cnt <= '0;
      rtw_cnt <= '0;
      rr_ptr  <= '0;
      bus_q   <= '0;
    end else begin
      rrd_cnt <= act_fire ? gap_load(t_rrd_i) : gap_dec(rrd_cnt);
      ccd_cnt <= (rd_fire || wr_fire) ? gap_load(t_ccd_i) : gap_dec(ccd_cnt);
      rtw_cnt <= rd_fire ? gap_load(t_rtw_i) : gap_dec(rtw_cnt);
      wtr_cnt <= wr_fire ? gap_load(t_wtr_i) : gap_dec(wtr_cnt);
      if (gnt_any) begin
        rr_ptr <= gnt_bank + BW'(1);
      end
      bus_q <= bus_d;
    end
  end

  assign cmd_valid_o = bus_q.vld;
  assign cmd_o       = bus_q.vld ? bus_q.cmd : CMD_NOP;
  assign cmd_ba_o    = bus_q.ba;
  assign cmd_addr_o  = bus_q.addr;
  assign cmd_id_o    = bus_q.id;
  assign cmd_len_o   = bus_q.len;

`ifdef SAL_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_act_o <= '0;
      perf_cas_o <= '0;
      perf_pre_o <= '0;
      perf_ref_o <= '0;
    end else begin
      if (act_fire)            perf_act_o <= perf_act_o + 32'd1;
      if (rd_fire || wr_fire)  perf_cas_o <= perf_cas_o + 32'd1;
      if (|pre_gnt_o)          perf_pre_o <= perf_pre_o + 32'd1;
      if (|ref_gnt_o)          perf_ref_o <= perf_ref_o + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(|(rd_req_i & wr_req_i)))
        else $error("sal_cmd_sched: bank requests RD and WR together (%b)", rd_req_i & wr_req_i);
    end
  end
`endif

endmodule

// File: tb/tb_sal_cmd_sched.sv
module tb_sal_cmd_sched;
  localparam int NB    = 4;
  localparam int RA_W  = 14;
  localparam int CA_W  = 10;
  localparam int ID_W  = 4;
  localparam int LEN_W = 4;
  localparam int TW    = 4;
  localparam int BW    = $clog2(NB);

  logic                   clk = 1'b0;
  logic                   rst;
  logic [TW-1:0]          t_rrd, t_ccd, t_wtr, t_rtw;
  logic [NB-1:0]          act_req, rd_req, wr_req, pre_req, ref_req;
  logic [NB*RA_W-1:0]     ra;
  logic [NB*CA_W-1:0]     ca;
  logic [NB*ID_W-1:0]     id;
  logic [NB*LEN_W-1:0]    len;
  logic [NB-1:0]          act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic                   cmd_valid;
  logic [2:0]             cmd;
  logic [BW-1:0]          cmd_ba;
  logic [RA_W-1:0]        cmd_addr;
  logic [ID_W-1:0]        cmd_id;
  logic [LEN_W-1:0]       cmd_len;
`ifdef SAL_SCHED_PERF_EN
  logic [31:0]            perf_act, perf_cas, perf_pre, perf_ref;
  int                     m_act, m_cas, m_pre, m_ref;
`endif

  sal_cmd_sched #(
    .NUM_BANKS(NB), .RA_W(RA_W), .CA_W(CA_W), .ID_W(ID_W), .LEN_W(LEN_W), .TW(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .t_rrd_i(t_rrd), .t_ccd_i(t_ccd), .t_wtr_i(t_wtr), .t_rtw_i(t_rtw),
    .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
    .pre_req_i(pre_req), .ref_req_i(ref_req),
    .ra_i(ra), .ca_i(ca), .id_i(id), .len_i(len),
    .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
    .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
    .cmd_valid_o(cmd_valid), .cmd_o(cmd), .cmd_ba_o(cmd_ba),
    .cmd_addr_o(cmd_addr), .cmd_id_o(cmd_id), .cmd_len_o(cmd_len)
`ifdef SAL_SCHED_PERF_EN
    ,
    .perf_act_o(perf_act), .perf_cas_o(perf_cas),
    .perf_pre_o(perf_pre), .perf_ref_o(perf_ref)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute cycle numbers at which each gap has expired.
  int cyc = 0;
  int act_at, ccd_at, wtr_at, rtw_at;
  int rr;
  logic            e_vld;
  logic [2:0]      e_cmd;
  logic [BW-1:0]   e_ba;
  logic [RA_W-1:0] e_addr;
  logic [ID_W-1:0] e_id;
  logic [LEN_W-1:0] e_len;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int gap(input logic [TW-1:0] t);
    return (t == '0) ? 1 : int'(t);
  endfunction

  task automatic model_reset();
    act_at = 0; ccd_at = 0; wtr_at = 0; rtw_at = 0;
    rr = 0;
    e_vld = 1'b0; e_cmd = 3'd0; e_ba = '0; e_addr = '0; e_id = '0; e_len = '0;
`ifdef SAL_SCHED_PERF_EN
    m_act = 0; m_cas = 0; m_pre = 0; m_ref = 0;
`endif
  endtask

  // kind uses the bus encoding: 0 none, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF.
  task automatic model_pick(output int kind, output int bank);
    kind = 0;
    bank = 0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < NB; k++) begin
        int b;
        b = (rr + k) % NB;
        if (kind == 0) begin
          case (c)
            0: if (ref_req[b]) kind = 5;
            1: begin
              if (rd_req[b]) begin
                if (cyc >= ccd_at && cyc >= wtr_at) kind = 2;
              end else if (wr_req[b] && cyc >= ccd_at && cyc >= rtw_at) begin
                kind = 3;
              end
            end
            2: if (act_req[b] && cyc >= act_at) kind = 1;
            default: if (pre_req[b]) kind = 4;
          endcase
          if (kind != 0) bank = b;
        end
      end
    end
  endtask

  // One cycle: compare at the falling edge, advance the model, return 1 after the next rising edge.
  task automatic tick();
    int kind, bank;
    logic [NB-1:0] oh;
    @(negedge clk);
    if (rst) begin
      model_reset();
      kind = 0;
      bank = 0;
    end else begin
      model_pick(kind, bank);
    end
    oh = (kind != 0) ? (NB'(1) << bank) : '0;
    chk("ref_gnt", ref_gnt, (kind == 5) ? oh : '0);
    chk("rd_gnt",  rd_gnt,  (kind == 2) ? oh : '0);
    chk("wr_gnt",  wr_gnt,  (kind == 3) ? oh : '0);
    chk("act_gnt", act_gnt, (kind == 1) ? oh : '0);
    chk("pre_gnt", pre_gnt, (kind == 4) ? oh : '0);
    chk("cmd_valid", cmd_valid, e_vld);
    chk("cmd",      cmd,      e_cmd);
    chk("cmd_ba",   cmd_ba,   e_ba);
    chk("cmd_addr", cmd_addr, e_addr);
    chk("cmd_id",   cmd_id,   e_id);
    chk("cmd_len",  cmd_len,  e_len);
`ifdef SAL_SCHED_PERF_EN
    chk("perf_act", perf_act, m_act);
    chk("perf_cas", perf_cas, m_cas);
    chk("perf_pre", perf_pre, m_pre);
    chk("perf_ref", perf_ref, m_ref);
`endif
    if (!rst) begin
      e_vld = (kind != 0);
      e_cmd = 3'(kind);
      e_ba  = (kind != 0) ? BW'(bank) : '0;
      e_addr = '0; e_id = '0; e_len = '0;
      case (kind)
        1: begin
          e_addr = ra[bank*RA_W +: RA_W];
          act_at = cyc + gap(t_rrd);
        end
        2, 3: begin
          e_addr = RA_W'(ca[bank*CA_W +: CA_W]);
          e_id   = id[bank*ID_W +: ID_W];
          e_len  = len[bank*LEN_W +: LEN_W];
          ccd_at = cyc + gap(t_ccd);
          if (kind == 2) rtw_at = cyc + gap(t_rtw);
          else           wtr_at = cyc + gap(t_wtr);
        end
        default: ;
      endcase
`ifdef SAL_SCHED_PERF_EN
      if (kind == 1) m_act++;
      if (kind == 2 || kind == 3) m_cas++;
      if (kind == 4) m_pre++;
      if (kind == 5) m_ref++;
`endif
      if (kind != 0) rr = (bank + 1) % NB;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    t_rrd = 4'd1; t_ccd = 4'd1; t_wtr = 4'd1; t_rtw = 4'd1;
    act_req = '1; rd_req = '0; wr_req = '1; pre_req = '1; ref_req = '1;
    ra  = (NB*RA_W)'({$urandom, $urandom});
    ca  = (NB*CA_W)'({$urandom, $urandom});
    id  = (NB*ID_W)'($urandom);
    len = (NB*LEN_W)'($urandom);
    repeat (2) @(posedge clk);
    #1;

    // Reset with everything requested: nothing granted, bus idle.
    #2;
    chk("rst_ref_gnt", ref_gnt, '0);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    tick();
    rst = 1'b0;
    #2;
    chk("rel_ref_bank0", ref_gnt, 4'b0001);
    tick();

    // Priority: RD bank2 beats ACT bank1 and PRE bank3, then ACT, then PRE.
    clear_reqs();
    act_req = 4'b0010; rd_req = 4'b0100; pre_req = 4'b1000;
    #2; chk("prio_rd", rd_gnt, 4'b0100); tick();
    rd_req = '0;
    #2; chk("prio_act", act_gnt, 4'b0010); tick();
    act_req = '0;
    #2; chk("prio_pre", pre_gnt, 4'b1000); tick();
    pre_req = '0;

    // Round-robin over four ACT requesters.
    act_req = 4'b1111; t_rrd = 4'd1;
    for (int i = 0; i < 5; i++) begin
      #2; chk("rr_act", act_gnt, NB'(1) << (i % NB));
      tick();
    end
    act_req = '0;
    pre_req = 4'b1000;
    tick();
    pre_req = '0;

    // tRRD=4: bank0 at 0, bank1 at 4, PRE fills the gap.
    t_rrd = 4'd4;
    for (int k = 0; k < 5; k++) begin
      act_req = (k == 0) ? 4'b0011 : 4'b0010;
      pre_req = (k >= 1 && k <= 3) ? 4'b0100 : 4'b0000;
      #2;
      chk("rrd_act", act_gnt, (k == 0) ? 4'b0001 : (k == 4) ? 4'b0010 : 4'b0000);
      if (k >= 1 && k <= 3) chk("rrd_pre", pre_gnt, 4'b0100);
      tick();
    end
    clear_reqs();

    // WR bank0 then RD bank1 held off by tWTR; WR bank2 only waits tCCD.
    t_wtr = 4'd6; t_ccd = 4'd2; t_rtw = 4'd1;
    for (int k = 0; k < 10; k++) begin
      wr_req = (k == 0) ? 4'b0001 : (k <= 2) ? 4'b0100 : 4'b0000;
      rd_req = (k >= 1 && k <= 8) ? 4'b0010 : 4'b0000;
      #2;
      if (k < 6) chk("wtr_rd_blocked", rd_gnt, 4'b0000);
      if (k == 2) chk("ccd_wr_bank2", wr_gnt, 4'b0100);
      tick();
    end
    clear_reqs();

    // Bus latency of one cycle, then NOP when idle.
    t_rrd = 4'd1;
    ra[2*RA_W +: RA_W] = 14'h1A5;
    act_req = 4'b0100;
    #2; chk("lat_act_gnt", act_gnt, 4'b0100); tick();
    act_req = '0;
    #2;
    chk("lat_cmd", cmd, 3'd1);
    chk("lat_ba", cmd_ba, 2'd2);
    chk("lat_addr", cmd_addr, 14'h1A5);
    tick();
    #2;
    chk("lat_nop_valid", cmd_valid, 1'b0);
    chk("lat_nop_cmd", cmd, 3'd0);

    // Asynchronous reset while a command is on the bus and rrd is loaded.
    t_rrd = 4'd7;
    act_req = 4'b1111;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cmd_valid", cmd_valid, 1'b0);
    chk("arst_act_gnt", act_gnt, 4'b0000);
    tick();
    rst = 1'b0;
    #2;
    chk("arst_rel_act0", act_gnt, 4'b0001);
    tick();

    // Randomised traffic against the model, including a mid-run reset.
    for (int n = 0; n < 400; n++) begin
      rst     = (n == 200);
      act_req = NB'($urandom) & NB'($urandom);
      rd_req  = NB'($urandom) & NB'($urandom);
      wr_req  = NB'($urandom) & ~rd_req;
      pre_req = NB'($urandom) & NB'($urandom) & NB'($urandom);
      ref_req = ($urandom_range(0, 7) == 0) ? (NB'($urandom) & NB'($urandom)) : '0;
      t_rrd = TW'($urandom_range(0, 6));
      t_ccd = TW'($urandom_range(0, 6));
      t_wtr = TW'($urandom_range(0, 6));
      t_rtw = TW'($urandom_range(0, 6));
      ra  = (NB*RA_W)'({$urandom, $urandom});
      ca  = (NB*CA_W)'({$urandom, $urandom});
      id  = (NB*ID_W)'($urandom);
      len = (NB*LEN_W)'($urandom);
      tick();
    end
    rst = 1'b0;
    clear_reqs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
